// File: rtl/lsp_select_1_pkg.sv
// Shared constants, saturation helpers and the constant-ROM image for the
// Lsp_select_1 first-stage search.
package lsp_select_1_pkg;

    localparam int NC        = 5;
    localparam int NC1       = 32;
    localparam int CB_STRIDE = 16;

    localparam logic [10:0] LSP_SELECT_1_RBUF  = 11'h100;
    localparam logic [10:0] LSP_SELECT_1_WEGT  = 11'h108;
    localparam logic [10:0] LSP_SELECT_1_INDEX = 11'h110;

    localparam logic [11:0] LSPCB1 = 12'h000;
    localparam logic [11:0] LSPCB2 = 12'h800;

    localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;

    // lspcb2 rows repeat with this period in the constant image
    localparam int ROW_PERIOD = 9;

    typedef enum logic [3:0] {
        IDLE, INIT, FETCH, WAIT, CALC, ACC, CMP, WRITE, DONE
    } state_e;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767)       return 16'sh7FFF;
        else if (x < -32'sd32768) return 16'sh8000;
        else                      return x[15:0];
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [32:0] x);
        if (x > 33'sh0_7FFF_FFFF)      return 32'sh7FFF_FFFF;
        else if (x < -33'sh0_8000_0000) return 32'sh8000_0000;
        else                            return x[31:0];
    endfunction

    // Constant image: Q13-range signed words, lspcb2 rows folded by ROW_PERIOD.
    function automatic logic [15:0] rom_image(input logic [11:0] a);
        int unsigned       key;
        int unsigned       base;
        logic signed [15:0] h;
        key  = {20'd0, a};
        base = {20'd0, LSPCB2};
        if (key >= base && key < base + NC1 * CB_STRIDE)
            key = base + (((key - base) / CB_STRIDE) % ROW_PERIOD) * CB_STRIDE
                + (key % CB_STRIDE);
        h = 16'((key * 32'd40503) ^ (key << 5) ^ 32'h0000_5A3C);
        return h >>> 2;
    endfunction

endpackage

// File: rtl/lsp_select_1_core.sv
// Lsp_select_1 search engine: FSM sequencing the row/coefficient loops and
// the saturating weighted-distance datapath.
module lsp_select_1_core
    import lsp_select_1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [11:0] lspcb1_addr_i,
    input  logic [15:0] ram_rdata_i,
    input  logic [15:0] rom_rdata_i,
    output logic [10:0] ram_raddr_o,
    output logic [10:0] ram_waddr_o,
    output logic [31:0] ram_wdata_o,
    output logic        ram_we_o,
    output logic [11:0] rom_addr_o,
    output logic        done_o
);

    state_e state_q, state_d;

    logic [2:0]         j_q;
    logic [4:0]         k_q;
    logic [4:0]         index_q;
    logic [11:0]        cb1_addr_q;
    logic signed [15:0] rbuf_q;
    logic signed [15:0] cb1_q;
    logic signed [31:0] term_q;
    logic signed [31:0] ldist_q;
    logic signed [31:0] ldmin_q;

    logic signed [15:0] wegt, cb2, d1, t, t2;
    logic signed [31:0] prod, psh, m, term, acc;

    assign ram_waddr_o = LSP_SELECT_1_INDEX;
    assign ram_wdata_o = {27'd0, index_q};

    // Per coefficient: FETCH issues rbuf/lspcb1, WAIT captures them and
    // issues wegt/lspcb2, CALC forms the term, ACC accumulates it.
    always_comb begin
        state_d     = state_q;
        done_o      = 1'b0;
        ram_we_o    = 1'b0;
        ram_raddr_o = '0;
        rom_addr_o  = '0;
        case (state_q)
            IDLE:  if (start_i) state_d = INIT;
            INIT:  state_d = FETCH;
            FETCH: begin
                ram_raddr_o = {LSP_SELECT_1_RBUF[10:3], j_q};
                rom_addr_o  = cb1_addr_q + 12'(j_q);
                state_d     = WAIT;
            end
            WAIT: begin
                ram_raddr_o = {LSP_SELECT_1_WEGT[10:3], j_q};
                rom_addr_o  = LSPCB2 + 12'(k_q) * 12'(CB_STRIDE) + 12'(j_q);
                state_d     = CALC;
            end
            CALC:  state_d = ACC;
            ACC:   state_d = (j_q == 3'(NC - 1)) ? CMP : FETCH;
            CMP:   state_d = (k_q == 5'(NC1 - 1)) ? WRITE : INIT;
            WRITE: begin
                ram_we_o = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wegt = ram_rdata_i;
        cb2  = rom_rdata_i;
        d1   = sat16(32'(rbuf_q) - 32'(cb1_q));
        t    = sat16(32'(d1) - 32'(cb2));
        prod = wegt * t;
        psh  = prod >>> 15;
        t2   = sat16(psh);
        m    = t2 * t;
        term = sat32({m, 1'b0});
        acc  = sat32(33'(ldist_q) + 33'(term_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            index_q    <= '0;
            cb1_addr_q <= '0;
            rbuf_q     <= '0;
            cb1_q      <= '0;
            term_q     <= '0;
            ldist_q    <= '0;
            ldmin_q    <= MAX_32;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start_i) begin
                    cb1_addr_q <= lspcb1_addr_i;
                    k_q        <= '0;
                    index_q    <= '0;
                    ldmin_q    <= MAX_32;
                end
                INIT: begin
                    j_q     <= '0;
                    ldist_q <= '0;
                end
                WAIT: begin
                    rbuf_q <= ram_rdata_i;
                    cb1_q  <= rom_rdata_i;
                end
                CALC: term_q <= term;
                ACC: begin
                    ldist_q <= acc;
                    j_q     <= j_q + 3'd1;
                end
                CMP: begin
                    // strict compare keeps the earliest row on ties
                    if (ldist_q < ldmin_q) begin
                        ldmin_q <= ldist_q;
                        index_q <= k_q;
                    end
                    k_q <= k_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lsp_select_1_unit.sv
// Stand-alone Lsp_select_1 unit: search core plus scratch RAM, constant ROM
// and the test-access muxes on the scratch port.
module lsp_select_1_unit
    import lsp_select_1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] lspcb1Addr,
    output logic [31:0] memIn,
    output logic        done,
    input  logic        lagMuxSel,
    input  logic        lagMux1Sel,
    input  logic        lagMux2Sel,
    input  logic        lagMux3Sel,
    input  logic [10:0] testReadRequested,
    input  logic [10:0] testWriteRequested,
    input  logic [31:0] testWriteOut,
    input  logic        testWriteEnable
);

    logic [10:0] core_raddr, core_waddr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic [11:0] rom_addr;

    logic [10:0] ram_raddr, ram_waddr;
    logic [31:0] ram_wdata;
    logic        ram_we;

    logic [31:0] ram [0:2047];
    logic [31:0] ram_q;
    logic [15:0] rom_q;

    assign ram_raddr = lagMuxSel  ? testReadRequested  : core_raddr;
    assign ram_waddr = lagMux1Sel ? testWriteRequested : core_waddr;
    assign ram_wdata = lagMux2Sel ? testWriteOut       : core_wdata;
    assign ram_we    = lagMux3Sel ? testWriteEnable    : core_we;

    assign memIn = ram_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        ram_q <= ram[ram_raddr];
    end

    always_ff @(posedge clk) begin
        rom_q <= rom_image(rom_addr);
    end

    lsp_select_1_core u_core (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .lspcb1_addr_i (lspcb1Addr),
        .ram_rdata_i   (ram_q[15:0]),
        .rom_rdata_i   (rom_q),
        .ram_raddr_o   (core_raddr),
        .ram_waddr_o   (core_waddr),
        .ram_wdata_o   (core_wdata),
        .ram_we_o      (core_we),
        .rom_addr_o    (rom_addr),
        .done_o        (done)
    );

endmodule

// File: tb/tb_lsp_select_1_unit.sv
// Self-checking bench for lsp_select_1_unit against a plain-arithmetic
// Lsp_select_1 reference model.
module tb_lsp_select_1_unit;
    import lsp_select_1_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] lspcb1Addr = '0;
    logic [31:0] memIn;
    logic        done;
    logic        lagMuxSel = 1'b0, lagMux1Sel = 1'b0, lagMux2Sel = 1'b0, lagMux3Sel = 1'b0;
    logic [10:0] testReadRequested = '0, testWriteRequested = '0;
    logic [31:0] testWriteOut = '0;
    logic        testWriteEnable = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int rb [NC];
    int wg [NC];
    logic [31:0] last_idx;

    always #5 clk = ~clk;

    lsp_select_1_unit dut (
        .clk(clk), .reset(reset), .start(start), .lspcb1Addr(lspcb1Addr),
        .memIn(memIn), .done(done),
        .lagMuxSel(lagMuxSel), .lagMux1Sel(lagMux1Sel),
        .lagMux2Sel(lagMux2Sel), .lagMux3Sel(lagMux3Sel),
        .testReadRequested(testReadRequested), .testWriteRequested(testWriteRequested),
        .testWriteOut(testWriteOut), .testWriteEnable(testWriteEnable)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        lagMux1Sel = 1'b1; lagMux2Sel = 1'b1; lagMux3Sel = 1'b1;
        testWriteRequested = a; testWriteOut = d; testWriteEnable = 1'b1;
        tick();
        lagMux1Sel = 1'b0; lagMux2Sel = 1'b0; lagMux3Sel = 1'b0;
        testWriteEnable = 1'b0;
    endtask

    task automatic rd(input logic [10:0] a, output logic [31:0] d);
        lagMuxSel = 1'b1; testReadRequested = a;
        tick();
        d = memIn;
        lagMuxSel = 1'b0;
    endtask

    function automatic longint rom16(input int a);
        logic [15:0] w;
        w = rom_image(12'(a));
        return longint'($signed(w));
    endfunction

    function automatic longint s16(input longint x);
        return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
    endfunction

    function automatic longint s32(input longint x);
        return (x > 64'sd2147483647) ? 64'sd2147483647 :
               (x < -64'sd2147483648) ? -64'sd2147483648 : x;
    endfunction

    // Bit-exact Lsp_select_1 over the current rb/wg vectors.
    function automatic int model(input int l1a);
        longint best, ld, a, t, t2;
        int idx;
        best = 64'sd2147483647;
        idx  = 0;
        for (int k = 0; k < NC1; k++) begin
            ld = 0;
            for (int j = 0; j < NC; j++) begin
                a  = s16(longint'(rb[j]) - rom16(l1a + j));
                t  = s16(a - rom16(int'(LSPCB2) + k * CB_STRIDE + j));
                t2 = s16((longint'(wg[j]) * t) >>> 15);
                ld = s32(ld + s32(2 * t2 * t));
            end
            if (ld < best) begin
                best = ld;
                idx  = k;
            end
        end
        return idx;
    endfunction

    task automatic load_vec();
        for (int j = 0; j < NC; j++) begin
            wr({LSP_SELECT_1_RBUF[10:3], 3'(j)}, {16'h0, 16'(rb[j])});
            wr({LSP_SELECT_1_WEGT[10:3], 3'(j)}, {16'h0, 16'(wg[j])});
        end
    endtask

    task automatic run_check(input string tag, input int l1a);
        logic [31:0] idx;
        int exp;
        bit seen;
        exp = model(l1a);
        load_vec();
        wr(LSP_SELECT_1_INDEX, 32'hDEAD_BEEF);
        lspcb1Addr = 12'(l1a);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        check32({tag, "_done"}, {31'd0, seen}, 32'd1);
        tick();
        check32({tag, "_pulse"}, {31'd0, done}, 32'd0);
        rd(LSP_SELECT_1_INDEX, idx);
        check32({tag, "_idx"}, idx, 32'(exp));
        last_idx = idx;
    endtask

    initial begin
        logic [31:0] r;
        int l1a, pulses;

        repeat (3) tick();
        check32("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check32("idle_done", {31'd0, done}, 32'd0);

        wr(11'h7F0, 32'h0000_1234);
        rd(11'h7F0, r);
        check32("test_rw", r, 32'h0000_1234);

        // exact match of row 7
        l1a = int'(LSPCB1) + 80 * CB_STRIDE;
        for (int j = 0; j < NC; j++) begin
            rb[j] = int'(rom16(l1a + j) + rom16(int'(LSPCB2) + 7 * CB_STRIDE + j));
            wg[j] = 16'h4000;
        end
        run_check("row7", l1a);
        check32("row7_const", last_idx, 32'd7);

        for (int j = 0; j < NC; j++) begin
            rb[j] = int'($urandom_range(0, 65535)) - 32768;
            wg[j] = 0;
        end
        run_check("zero_wegt", l1a);
        check32("zero_wegt_const", last_idx, 32'd0);

        // rows 3 and 12 share an image row: equal minimum, earlier wins
        for (int j = 0; j < NC; j++) begin
            rb[j] = int'(rom16(l1a + j) + rom16(int'(LSPCB2) + 3 * CB_STRIDE + j));
            wg[j] = 16'h4000;
        end
        run_check("tie", l1a);
        check32("tie_const", last_idx, 32'd3);

        for (int j = 0; j < NC; j++) begin
            rb[j] = 32767;
            wg[j] = 32767;
        end
        run_check("sat", l1a);

        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < NC; j++) begin
                rb[j] = int'($urandom_range(0, 65535)) - 32768;
                wg[j] = int'($urandom_range(0, 32767));
            end
            run_check($sformatf("vec%0d", v), int'(LSPCB1) + ((v == 4) ? 72 : 80) * CB_STRIDE);
        end

        // reset in the middle of a search
        wr(LSP_SELECT_1_INDEX, 32'hA5A5_A5A5);
        lspcb1Addr = 12'(l1a);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 900; c++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        check32("midreset_nodone", 32'(pulses), 32'd0);
        rd(LSP_SELECT_1_INDEX, r);
        check32("midreset_index", r, 32'hA5A5_A5A5);
        run_check("after_reset", l1a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
